// File: rtl/m68k_sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m68k_sdram_pkg
// Purpose  : Shared states, command encodings and timing defaults for the
//            68k cache-line SDRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package m68k_sdram_pkg;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRECHARGE,
    ST_INIT_REFRESH,
    ST_INIT_LOAD_MODE,
    ST_IDLE,
    ST_READ,
    ST_READ_BURST,
    ST_WRITE,
    ST_WRITE_RECOVER,
    ST_ACK
  } state_t;

  // {RAS_L, CAS_L, WE_L} with CS_L low
  localparam logic [2:0] c_CMD_NOP       = 3'b111;
  localparam logic [2:0] c_CMD_ACTIVE    = 3'b011;
  localparam logic [2:0] c_CMD_READ      = 3'b101;
  localparam logic [2:0] c_CMD_WRITE     = 3'b100;
  localparam logic [2:0] c_CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] c_CMD_REFRESH   = 3'b001;
  localparam logic [2:0] c_CMD_LOADMODE  = 3'b000;

  // BL=8, sequential, CL=2, burst read / burst write
  localparam logic [12:0] c_MODE_REG = 13'b000_0_00_010_0_011;
  localparam logic [12:0] c_A10      = 13'h0400;
  localparam int unsigned c_BURST_LEN = 8;

  localparam int unsigned c_DEF_INIT_WAIT_CYCLES = 5000;
  localparam int unsigned c_DEF_REFRESH_INTERVAL = 375;
  localparam int unsigned c_DEF_T_RP             = 2;
  localparam int unsigned c_DEF_T_RFC            = 4;
  localparam int unsigned c_DEF_T_RCD            = 2;
  localparam int unsigned c_DEF_T_MRD            = 2;
  localparam int unsigned c_DEF_T_WRP            = 3;
  localparam int unsigned c_DEF_CAS_LATENCY      = 2;

  // Column address with A10 set so every access auto-precharges
  function automatic logic [12:0] col_addr(input logic [8:0] col);
    return {2'b00, 1'b1, 1'b0, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/m68k_sdram_controller_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_refresh_timer
// Purpose  : Free-running refresh interval counter with a sticky request flag.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_refresh_timer
  import m68k_sdram_pkg::*;
#(
  parameter int unsigned INTERVAL = c_DEF_REFRESH_INTERVAL
) (
  input  logic Clock,
  input  logic Reset_H,
  input  logic Enable_H,
  input  logic Clear_H,
  output logic Pending_H
);

  localparam int unsigned c_CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(INTERVAL - 1);

  logic [c_CNT_W-1:0] r_count;
  logic               r_pending;
  logic               w_wrap;

  assign w_wrap = Enable_H && (r_count == c_LAST);

  // A wrap while already pending just keeps the single flag set
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (Enable_H)
        r_count <= w_wrap ? '0 : r_count + 1'b1;
      if (w_wrap)
        r_pending <= 1'b1;
      else if (Clear_H)
        r_pending <= 1'b0;
    end
  end

  assign Pending_H = r_pending;

endmodule
`default_nettype wire

// File: rtl/m68k_sdram_controller.sv
`default_nettype none
// ============================================================================
// Module   : m68k_sdram_controller
// Purpose  : Converts 68k cache bus cycles into SDRAM burst reads, masked
//            single writes, init and auto-refresh.
// Revision : 1.0 - initial release
// ============================================================================
module m68k_sdram_controller
  import m68k_sdram_pkg::*;
#(
  parameter int unsigned INIT_WAIT_CYCLES = c_DEF_INIT_WAIT_CYCLES,
  parameter int unsigned REFRESH_INTERVAL = c_DEF_REFRESH_INTERVAL,
  parameter int unsigned T_RP             = c_DEF_T_RP,
  parameter int unsigned T_RFC            = c_DEF_T_RFC,
  parameter int unsigned T_RCD            = c_DEF_T_RCD,
  parameter int unsigned T_MRD            = c_DEF_T_MRD,
  parameter int unsigned T_WRP            = c_DEF_T_WRP,
  parameter int unsigned CAS_LATENCY      = c_DEF_CAS_LATENCY
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic        DramSelect_L,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic        UDS_L,
  input  logic        LDS_L,
  input  logic [31:0] Address,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Dtack_L,
  output logic        SDram_CKE_H,
  output logic        SDram_CS_L,
  output logic        SDram_RAS_L,
  output logic        SDram_CAS_L,
  output logic        SDram_WE_L,
  output logic [12:0] SDram_Addr,
  output logic [1:0]  SDram_BA,
  output logic [1:0]  SDram_DQM,
  input  logic [15:0] SDram_DQ_In,
  output logic [15:0] SDram_DQ_Out,
  output logic        SDram_DQ_OE_H
);

  localparam int unsigned c_CNT_W = $clog2(INIT_WAIT_CYCLES + CAS_LATENCY + c_BURST_LEN + 1);

  state_t             r_state, w_state_next;
  logic [c_CNT_W-1:0] r_wait, w_wait_next;
  logic               r_cke;
  logic               r_cs_l, w_cs_l;
  logic [2:0]         r_cmd, w_cmd;
  logic [12:0]        r_addr, w_addr;
  logic [1:0]         r_ba, w_ba;
  logic [1:0]         r_dqm, w_dqm;
  logic               r_oe, w_oe;
  logic [15:0]        r_dq_out, w_dq_out;
  logic               r_dtack_l, w_dtack_l;
  logic               w_go, w_bus_req, w_refresh_pending, w_refresh_issue, w_timer_en;
  logic               w_unused_addr;

  assign w_unused_addr = &{1'b0, Address[31:25], Address[0]};
  assign w_go       = (r_wait == '0);
  assign w_bus_req  = !DramSelect_L && !AS_L;
  assign w_timer_en = !(r_state inside {ST_INIT_WAIT, ST_INIT_PRECHARGE,
                                        ST_INIT_REFRESH, ST_INIT_LOAD_MODE});

  sdram_refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .Clock     (Clock),
    .Reset_H   (Reset_H),
    .Enable_H  (w_timer_en),
    .Clear_H   (w_refresh_issue),
    .Pending_H (w_refresh_pending)
  );

  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      r_state   <= ST_INIT_WAIT;
      r_wait    <= c_CNT_W'(INIT_WAIT_CYCLES);
      r_cke     <= 1'b0;
      r_cs_l    <= 1'b1;
      r_cmd     <= c_CMD_NOP;
      r_addr    <= '0;
      r_ba      <= '0;
      r_dqm     <= 2'b11;
      r_oe      <= 1'b0;
      r_dq_out  <= '0;
      r_dtack_l <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_wait    <= w_wait_next;
      r_cke     <= 1'b1;
      r_cs_l    <= w_cs_l;
      r_cmd     <= w_cmd;
      r_addr    <= w_addr;
      r_ba      <= w_ba;
      r_dqm     <= w_dqm;
      r_oe      <= w_oe;
      r_dq_out  <= w_dq_out;
      r_dtack_l <= w_dtack_l;
    end
  end

  // Every state idles on NOP while the shared wait counter drains, then acts
  always_comb begin
    w_state_next    = r_state;
    w_wait_next     = w_go ? '0 : r_wait - 1'b1;
    w_cs_l          = 1'b0;
    w_cmd           = c_CMD_NOP;
    w_addr          = '0;
    w_ba            = '0;
    w_dqm           = 2'b11;
    w_oe            = 1'b0;
    w_dq_out        = r_dq_out;
    w_dtack_l       = 1'b1;
    w_refresh_issue = 1'b0;
    case (r_state)
      ST_INIT_WAIT: if (w_go) begin
        w_cmd        = c_CMD_PRECHARGE;
        w_addr       = c_A10;
        w_wait_next  = c_CNT_W'(T_RP);
        w_state_next = ST_INIT_PRECHARGE;
      end
      ST_INIT_PRECHARGE: if (w_go) begin
        w_cmd        = c_CMD_REFRESH;
        w_wait_next  = c_CNT_W'(T_RFC);
        w_state_next = ST_INIT_REFRESH;
      end
      ST_INIT_REFRESH: if (w_go) begin
        w_cmd        = c_CMD_REFRESH;
        w_wait_next  = c_CNT_W'(T_RFC);
        w_state_next = ST_INIT_LOAD_MODE;
      end
      ST_INIT_LOAD_MODE: if (w_go) begin
        w_cmd        = c_CMD_LOADMODE;
        w_addr       = c_MODE_REG;
        w_wait_next  = c_CNT_W'(T_MRD);
        w_state_next = ST_IDLE;
      end
      ST_IDLE: if (w_go) begin
        if (w_refresh_pending) begin
          w_cmd           = c_CMD_REFRESH;
          w_wait_next     = c_CNT_W'(T_RFC);
          w_refresh_issue = 1'b1;
        end else if (w_bus_req) begin
          w_cmd        = c_CMD_ACTIVE;
          w_addr       = Address[22:10];
          w_ba         = Address[24:23];
          w_wait_next  = c_CNT_W'(T_RCD);
          w_state_next = WE_L ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: if (w_go) begin
        w_cmd        = c_CMD_READ;
        w_addr       = col_addr(Address[9:1]);
        w_ba         = Address[24:23];
        w_dqm        = 2'b00;
        w_wait_next  = c_CNT_W'(CAS_LATENCY + c_BURST_LEN);
        w_state_next = ST_READ_BURST;
      end
      ST_WRITE: if (w_go) begin
        w_cmd        = c_CMD_WRITE;
        w_addr       = col_addr(Address[9:1]);
        w_ba         = Address[24:23];
        w_dqm        = {UDS_L, LDS_L};
        w_oe         = 1'b1;
        w_dq_out     = DataIn;
        w_wait_next  = c_CNT_W'(T_WRP);
        w_state_next = ST_WRITE_RECOVER;
      end
      ST_READ_BURST, ST_WRITE_RECOVER: begin
        if (!w_go && r_state == ST_READ_BURST)
          w_dqm = 2'b00;
        // A strobe already released skips the acknowledge entirely
        if (w_go) begin
          w_dtack_l    = !w_bus_req;
          w_state_next = w_bus_req ? ST_ACK : ST_IDLE;
        end
      end
      ST_ACK: begin
        w_dtack_l    = !w_bus_req;
        w_state_next = w_bus_req ? ST_ACK : ST_IDLE;
      end
      default: w_state_next = ST_INIT_WAIT;
    endcase
  end

  assign DataOut       = SDram_DQ_In;
  assign Dtack_L       = r_dtack_l;
  assign SDram_CKE_H   = r_cke;
  assign SDram_CS_L    = r_cs_l;
  assign SDram_RAS_L   = r_cmd[2];
  assign SDram_CAS_L   = r_cmd[1];
  assign SDram_WE_L    = r_cmd[0];
  assign SDram_Addr    = r_addr;
  assign SDram_BA      = r_ba;
  assign SDram_DQM     = r_dqm;
  assign SDram_DQ_Out  = r_dq_out;
  assign SDram_DQ_OE_H = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_m68k_sdram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_m68k_sdram_controller
// Purpose  : Directed self-checking bench for the 68k SDRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m68k_sdram_controller;

  logic        Clock = 1'b0;
  logic        Reset_H = 1'b1;
  logic        DramSelect_L = 1'b1;
  logic        AS_L = 1'b1;
  logic        WE_L = 1'b1;
  logic        UDS_L = 1'b1;
  logic        LDS_L = 1'b1;
  logic [31:0] Address = '0;
  logic [15:0] DataIn = '0;
  logic [15:0] DataOut;
  logic        Dtack_L;
  logic        SDram_CKE_H;
  logic        SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L;
  logic [12:0] SDram_Addr;
  logic [1:0]  SDram_BA;
  logic [1:0]  SDram_DQM;
  logic [15:0] SDram_DQ_In = '0;
  logic [15:0] SDram_DQ_Out;
  logic        SDram_DQ_OE_H;

  logic [3:0]  cmd4;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  mem_b0 = 8'h00;
  logic [7:0]  mem_b1 = 8'h00;

  assign cmd4 = {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L};

  m68k_sdram_controller dut (
    .Clock         (Clock),
    .Reset_H       (Reset_H),
    .DramSelect_L  (DramSelect_L),
    .AS_L          (AS_L),
    .WE_L          (WE_L),
    .UDS_L         (UDS_L),
    .LDS_L         (LDS_L),
    .Address       (Address),
    .DataIn        (DataIn),
    .DataOut       (DataOut),
    .Dtack_L       (Dtack_L),
    .SDram_CKE_H   (SDram_CKE_H),
    .SDram_CS_L    (SDram_CS_L),
    .SDram_RAS_L   (SDram_RAS_L),
    .SDram_CAS_L   (SDram_CAS_L),
    .SDram_WE_L    (SDram_WE_L),
    .SDram_Addr    (SDram_Addr),
    .SDram_BA      (SDram_BA),
    .SDram_DQM     (SDram_DQM),
    .SDram_DQ_In   (SDram_DQ_In),
    .SDram_DQ_Out  (SDram_DQ_Out),
    .SDram_DQ_OE_H (SDram_DQ_OE_H)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until the next non-NOP command, giving up after budget cycles
  task automatic next_cmd(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (cmd4 == 4'b0111 && n < budget);
  endtask

  initial begin
    int r, a, w, nref, nother;
    int tref [0:3];
    for (int i = 0; i < 4; i++) tref[i] = 0;

    // Reset state
    repeat (3) step();
    check("rst_cke", SDram_CKE_H, 0);
    check("rst_cmd", cmd4, 4'b1111);
    check("rst_addr", SDram_Addr, 0);
    check("rst_ba", SDram_BA, 0);
    check("rst_dqm", SDram_DQM, 2'b11);
    check("rst_oe", SDram_DQ_OE_H, 0);
    check("rst_dqout", SDram_DQ_Out, 0);
    check("rst_dtack", Dtack_L, 1);

    // Power-up sequence
    Reset_H = 1'b0;
    cyc = 0;
    step();
    check("pu_cke", SDram_CKE_H, 1);
    check("pu_nop", cmd4, 4'b0111);
    next_cmd(6000);
    check("pu_pre_cmd", cmd4, 4'b0010);
    check("pu_pre_cyc", cyc, 5001);
    check("pu_pre_a10", SDram_Addr[10], 1);
    next_cmd(20);
    check("pu_ref1_cmd", cmd4, 4'b0001);
    check("pu_ref1_cyc", cyc, 5004);
    next_cmd(20);
    check("pu_ref2_cmd", cmd4, 4'b0001);
    check("pu_ref2_cyc", cyc, 5009);
    next_cmd(20);
    check("pu_lm_cmd", cmd4, 4'b0000);
    check("pu_lm_cyc", cyc, 5014);
    check("pu_lm_addr", SDram_Addr, 13'h023);

    // Burst read at 0x0123_4560, request raised before init completes
    Address = 32'h0123_4560; WE_L = 1'b1; AS_L = 1'b0; DramSelect_L = 1'b0;
    next_cmd(20);
    check("rd_act_cmd", cmd4, 4'b0011);
    check("rd_act_cyc", cyc, 5017);
    check("rd_act_ba", SDram_BA, 2);
    check("rd_act_row", SDram_Addr, 13'h08D1);
    check("rd_act_dtack", Dtack_L, 1);
    next_cmd(20);
    r = cyc;
    check("rd_cmd", cmd4, 4'b0101);
    check("rd_cyc", r, 5020);
    check("rd_col", SDram_Addr, 13'h04B0);
    check("rd_ba", SDram_BA, 2);
    check("rd_dqm", SDram_DQM, 2'b00);
    step(); step();
    check("rd_single_cas", cmd4, 4'b0111);
    for (int k = 0; k < 8; k++) begin
      step();
      SDram_DQ_In = 16'hA000 + 16'(k);
      #1;
      check("rd_word", DataOut, 32'hA000 + k);
    end
    check("rd_no_early_ack", Dtack_L, 1);
    step();
    check("rd_ack_cyc", cyc, r + 11);
    check("rd_ack", Dtack_L, 0);
    step();
    check("rd_ack_hold", Dtack_L, 0);
    AS_L = 1'b1; DramSelect_L = 1'b1;
    step();
    check("rd_ack_release", Dtack_L, 1);

    // Masked single write of 0xBEEF at 0x102, lower byte only
    Address = 32'h0000_0102; DataIn = 16'hBEEF; WE_L = 1'b0; UDS_L = 1'b1; LDS_L = 1'b0;
    AS_L = 1'b0; DramSelect_L = 1'b0;
    next_cmd(20);
    a = cyc;
    check("wr_act_cmd", cmd4, 4'b0011);
    check("wr_act_ba", SDram_BA, 0);
    check("wr_act_row", SDram_Addr, 0);
    next_cmd(20);
    w = cyc;
    check("wr_cmd", cmd4, 4'b0100);
    check("wr_cyc", w, a + 3);
    check("wr_col", SDram_Addr, 13'h0481);
    check("wr_dqm", SDram_DQM, 2'b10);
    check("wr_oe", SDram_DQ_OE_H, 1);
    check("wr_data", SDram_DQ_Out, 16'hBEEF);
    if (!SDram_DQM[0]) mem_b0 = SDram_DQ_Out[7:0];
    if (!SDram_DQM[1]) mem_b1 = SDram_DQ_Out[15:8];
    check("wr_mem_b0", mem_b0, 8'hEF);
    check("wr_mem_b1", mem_b1, 8'h00);
    step();
    check("wr_rec_oe", SDram_DQ_OE_H, 0);
    check("wr_rec_dqm", SDram_DQM, 2'b11);
    step(); step();
    check("wr_no_early_ack", Dtack_L, 1);
    step();
    check("wr_ack", Dtack_L, 0);
    AS_L = 1'b1; DramSelect_L = 1'b1; WE_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    step();
    check("wr_ack_release", Dtack_L, 1);

    // Request lands on the cycle the refresh flag rises
    nother = 0;
    while (cyc < 5389) begin
      step();
      if (cmd4 != 4'b0111) nother++;
    end
    check("quiet_before_ref", nother, 0);
    Address = 32'h0000_0040; AS_L = 1'b0; DramSelect_L = 1'b0;
    next_cmd(20);
    check("col_ref_cmd", cmd4, 4'b0001);
    check("col_ref_cyc", cyc, 5390);
    next_cmd(20);
    check("col_act_cmd", cmd4, 4'b0011);
    check("col_act_cyc", cyc, 5395);
    next_cmd(20);
    r = cyc;
    check("col_rd_cmd", cmd4, 4'b0101);
    check("col_rd_col", SDram_Addr, 13'h0420);
    step(); step();
    for (int k = 0; k < 8; k++) begin
      step();
      SDram_DQ_In = 16'h5A00 + 16'(k);
      #1;
      check("col_word", DataOut, 32'h5A00 + k);
      if (k == 2) AS_L = 1'b1;
    end
    step();
    check("early_term_no_ack", Dtack_L, 1);
    check("early_term_nop", cmd4, 4'b0111);
    step();
    check("early_term_idle", Dtack_L, 1);
    DramSelect_L = 1'b1;

    // Refresh cadence while idle
    nref = 0; nother = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (cmd4 == 4'b0001) begin
        if (nref < 4) tref[nref] = cyc;
        nref++;
      end else if (cmd4 != 4'b0111) nother++;
    end
    check("cad_count", nref, 3);
    check("cad_other", nother, 0);
    check("cad_first", tref[0], 5765);
    check("cad_gap1", tref[1] - tref[0], 375);
    check("cad_gap2", tref[2] - tref[1], 375);

    // Reset during burst word 4
    Address = 32'h0080_0010; AS_L = 1'b0; DramSelect_L = 1'b0;
    next_cmd(20);
    check("mr_act_cmd", cmd4, 4'b0011);
    next_cmd(20);
    check("mr_rd_cmd", cmd4, 4'b0101);
    step(); step();
    for (int k = 0; k < 5; k++) begin
      step();
      SDram_DQ_In = 16'hC000 + 16'(k);
    end
    Reset_H = 1'b1;
    #1;
    check("mr_cs", SDram_CS_L, 1);
    check("mr_cmd", cmd4, 4'b1111);
    check("mr_dqm", SDram_DQM, 2'b11);
    check("mr_dtack", Dtack_L, 1);
    check("mr_cke", SDram_CKE_H, 0);
    AS_L = 1'b1; DramSelect_L = 1'b1;
    step(); step();
    Reset_H = 1'b0;
    cyc = 0;
    step();
    check("mr_pu_cke", SDram_CKE_H, 1);
    next_cmd(6000);
    check("mr_pre_cmd", cmd4, 4'b0010);
    check("mr_pre_cyc", cyc, 5001);
    next_cmd(20);
    check("mr_ref_cmd", cmd4, 4'b0001);
    check("mr_ref_cyc", cyc, 5004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
